pulse_sequencer: RTL and testbench

Fetch/execute controller directly downstream of the 128×32 instruction memory. Drives the memory address, consumes the registered instruction word one cycle later, and executes it. Produces per-channel amplitude updates, wait delays, jumps and halt. Program flow is started by a single `start` pulse and ends on HALT or on an illegal opcode.

---
 rtl/seq_pkg.sv | 28 ++
 rtl/seq_wait_timer.sv | 37 +++
 rtl/pulse_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_pulse_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the pulse sequencer: opcodes, FSM states and
// instruction field positions.
package seq_pkg;

   // Opcode values carried in the top nibble of each instruction word
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_PLAY = 4'h1;
   localparam logic [3:0] OP_WAIT = 4'h2;
   localparam logic [3:0] OP_JUMP = 4'h3;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Controller states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_WAIT,
      ST_HALTED
   } state_t;

   // Instruction field bit positions
   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 28;
   localparam int unsigned CH_BIT  = 27;
   localparam int unsigned ARG_MSB = 7;
   localparam int unsigned ARG_LSB = 0;

endpackage

// File: rtl/seq_wait_timer.sv
// Loadable down-counter used to time WAIT instructions; flags when it
// has reached zero.
module seq_wait_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   // Load has priority; otherwise count down while enabled, stopping at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Fetch/execute controller for a 128-word instruction memory with a
// one-cycle registered read. Produces per-channel amplitude updates,
// timed waits, jumps and halt.
module pulse_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned ADDR_W     = 7,
   parameter int unsigned INSTR_W    = 32,
   parameter int unsigned AMP_W      = 8,
   parameter int unsigned START_ADDR = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [ADDR_W-1:0]  addr,
   input  logic [INSTR_W-1:0] instr,
   output logic [AMP_W-1:0]   amp0,
   output logic [AMP_W-1:0]   amp1,
   output logic               amp_stb0,
   output logic               amp_stb1,
   output logic               busy,
   output logic               done,
   output logic               err
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [AMP_W-1:0]    amp0_q, amp0_d;
   logic [AMP_W-1:0]    amp1_q, amp1_d;
   logic                stb0_q, stb0_d;
   logic                stb1_q, stb1_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic [3:0]          opcode;
   logic                chan;
   logic [AMP_W-1:0]    arg;

   logic                tmr_load;
   logic                tmr_en;
   logic [AMP_W-1:0]    tmr_value;
   logic                tmr_zero;

   // Bits between the channel and argument fields carry no meaning
   logic                unused_instr_bits;

   assign opcode = instr[OPC_MSB:OPC_LSB];
   assign chan   = instr[CH_BIT];
   assign arg    = instr[ARG_LSB +: AMP_W];
   assign unused_instr_bits = ^instr[CH_BIT-1:ARG_MSB+1];

   seq_wait_timer #(
      .W (AMP_W)
   ) u_wait_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .en    (tmr_en),
      .value (tmr_value),
      .zero  (tmr_zero)
   );

   // Next-state, PC, amplitude and status decode
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      amp0_d    = amp0_q;
      amp1_d    = amp1_q;
      stb0_d    = 1'b0;
      stb1_d    = 1'b0;
      done_d    = done_q;
      err_d     = err_q;
      tmr_load  = 1'b0;
      tmr_en    = 1'b0;
      // WAIT n spends n cycles in ST_WAIT, counting n-1 down to 0
      tmr_value = arg - AMP_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pc_d    = ADDR_W'(START_ADDR);
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            state_d = ST_EXEC;
         end

         ST_EXEC: begin
            case (opcode)
               OP_NOP: begin
                  pc_d    = pc_q + ADDR_W'(1);
                  state_d = ST_FETCH;
               end
               OP_PLAY: begin
                  if (chan) begin
                     amp1_d = arg;
                     stb1_d = 1'b1;
                  end else begin
                     amp0_d = arg;
                     stb0_d = 1'b1;
                  end
                  pc_d    = pc_q + ADDR_W'(1);
                  state_d = ST_FETCH;
               end
               OP_WAIT: begin
                  pc_d = pc_q + ADDR_W'(1);
                  if (arg == '0) begin
                     state_d = ST_FETCH;
                  end else begin
                     tmr_load = 1'b1;
                     state_d  = ST_WAIT;
                  end
               end
               OP_JUMP: begin
                  pc_d    = arg[ADDR_W-1:0];
                  state_d = ST_FETCH;
               end
               OP_HALT: begin
                  done_d  = 1'b1;
                  state_d = ST_HALTED;
               end
               default: begin
                  err_d   = 1'b1;
                  state_d = ST_HALTED;
               end
            endcase
         end

         ST_WAIT: begin
            if (tmr_zero) begin
               state_d = ST_FETCH;
            end else begin
               tmr_en = 1'b1;
            end
         end

         ST_HALTED: begin
            if (start) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               pc_d    = ADDR_W'(START_ADDR);
               state_d = ST_FETCH;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_FETCH) || (state_d == ST_EXEC) ||
               (state_d == ST_WAIT);
   end

   // State, PC and output registers; reset overrides everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         amp0_q  <= '0;
         amp1_q  <= '0;
         stb0_q  <= 1'b0;
         stb1_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         amp0_q  <= amp0_d;
         amp1_q  <= amp1_d;
         stb0_q  <= stb0_d;
         stb1_q  <= stb1_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign addr     = pc_q;
   assign amp0     = amp0_q;
   assign amp1     = amp1_q;
   assign amp_stb0 = stb0_q;
   assign amp_stb1 = stb1_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: a program-level trace model checks every
// cycle of the main instance; directed literal checks pin key timings.
module tb_pulse_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        start2;
   logic [6:0]  addr, addr2;
   logic [31:0] instr, instr2;
   logic [7:0]  amp0, amp1, amp0_2, amp1_2;
   logic        amp_stb0, amp_stb1, amp_stb0_2, amp_stb1_2;
   logic        busy, done, err, busy2, done2, err2;

   logic [31:0] mem [128];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   pulse_sequencer #(
      .ADDR_W     (7),
      .INSTR_W    (32),
      .AMP_W      (8),
      .START_ADDR (0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .addr     (addr),
      .instr    (instr),
      .amp0     (amp0),
      .amp1     (amp1),
      .amp_stb0 (amp_stb0),
      .amp_stb1 (amp_stb1),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   pulse_sequencer #(
      .ADDR_W     (7),
      .INSTR_W    (32),
      .AMP_W      (8),
      .START_ADDR (127)
   ) dut_wrap (
      .clk      (clk),
      .rst      (rst),
      .start    (start2),
      .addr     (addr2),
      .instr    (instr2),
      .amp0     (amp0_2),
      .amp1     (amp1_2),
      .amp_stb0 (amp_stb0_2),
      .amp_stb1 (amp_stb1_2),
      .busy     (busy2),
      .done     (done2),
      .err      (err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory with a registered read port
   always @(posedge clk) begin
      instr  <= mem[addr];
      instr2 <= mem[addr2];
   end

   function automatic logic [31:0] mk(input logic [3:0] op, input logic ch,
                                      input logic [7:0] arg);
      return {op, ch, 19'd0, arg};
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [6:0] addr;
      logic [7:0] amp0;
      logic [7:0] amp1;
      logic       stb0;
      logic       stb1;
      logic       busy;
      logic       done;
      logic       err;
   } obs_t;

   obs_t q[$];
   obs_t exp_cur;
   obs_t steady;
   bit   known = 1'b0;

   // Interpret the program from address 0 and queue the visible outputs of
   // every cycle of the run; the final halted view goes into 'steady'.
   task automatic build_trace();
      logic [6:0]  pc;
      logic [7:0]  a0, a1, arg;
      logic [3:0]  op;
      logic [31:0] w;
      logic        p0, p1, ch;
      pc = 7'd0;
      a0 = steady.amp0;
      a1 = steady.amp1;
      p0 = 1'b0;
      p1 = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         q.push_back('{pc, a0, a1, p0, p1, 1'b1, 1'b0, 1'b0});
         p0 = 1'b0;
         p1 = 1'b0;
         q.push_back('{pc, a0, a1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
         w   = mem[pc];
         op  = w[31:28];
         ch  = w[27];
         arg = w[7:0];
         if (op == 4'h0) begin
            pc = pc + 7'd1;
         end else if (op == 4'h1) begin
            if (ch) begin a1 = arg; p1 = 1'b1; end
            else    begin a0 = arg; p0 = 1'b1; end
            pc = pc + 7'd1;
         end else if (op == 4'h2) begin
            pc = pc + 7'd1;
            for (int k = 0; k < int'(arg); k++)
               q.push_back('{pc, a0, a1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
         end else if (op == 4'h3) begin
            pc = arg[6:0];
         end else begin
            steady = '{pc, a0, a1, 1'b0, 1'b0, 1'b0, op == 4'hF, op != 4'hF};
            return;
         end
      end
      steady = '{pc, a0, a1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   endtask

   // Compare this cycle's outputs, then advance the model using the inputs
   // that the next rising edge will sample
   always @(negedge clk) begin
      obs_t act;
      act = '{addr, amp0, amp1, amp_stb0, amp_stb1, busy, done, err};
      if (known) begin
         checks++;
         if (act !== exp_cur) begin
            errors++;
            $display("FAIL trace cyc=%0d got addr=%h amp0=%h amp1=%h stb=%b%b busy=%b done=%b err=%b required addr=%h amp0=%h amp1=%h stb=%b%b busy=%b done=%b err=%b",
                     cyc, act.addr, act.amp0, act.amp1, act.stb0, act.stb1,
                     act.busy, act.done, act.err, exp_cur.addr, exp_cur.amp0,
                     exp_cur.amp1, exp_cur.stb0, exp_cur.stb1, exp_cur.busy,
                     exp_cur.done, exp_cur.err);
         end
      end
      if (rst) begin
         q.delete();
         steady  = '0;
         exp_cur = '0;
         known   = 1'b1;
      end else if (known) begin
         if (start && !exp_cur.busy) build_trace();
         if (q.size() > 0) exp_cur = q.pop_front();
         else              exp_cur = steady;
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic lit(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h required=%0h", name, got, want);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 128; i++) mem[i] = mk(4'hF, 1'b0, 8'h00);
   endtask

   initial begin
      logic [31:0] r;
      logic [7:0]  tgt;
      rst    = 1'b1;
      start  = 1'b0;
      start2 = 1'b0;
      clear_mem();
      tick(3);
      rst = 1'b0;
      lit("reset_addr", addr, 0);
      lit("reset_busy", busy, 0);
      lit("reset_amp0", amp0, 0);
      lit("reset_done", done, 0);

      // PLAY ch0 0x55; PLAY ch1 0xAA; HALT
      mem[0] = mk(4'h1, 1'b0, 8'h55);
      mem[1] = mk(4'h1, 1'b1, 8'hAA);
      mem[2] = mk(4'hF, 1'b0, 8'h00);
      do_start();
      lit("A_first_fetch_addr", addr, 0);
      lit("A_first_fetch_busy", busy, 1);
      tick(2);
      lit("A_amp0", amp0, 8'h55);
      lit("A_stb0", amp_stb0, 1);
      tick(1);
      lit("A_stb0_one_cycle", amp_stb0, 0);
      tick(1);
      lit("A_amp1", amp1, 8'hAA);
      lit("A_stb1", amp_stb1, 1);
      tick(2);
      lit("A_done", done, 1);
      lit("A_busy_low", busy, 0);
      tick(3);
      lit("A_done_held", done, 1);

      // WAIT 5; PLAY ch0 0x01; HALT
      mem[0] = mk(4'h2, 1'b0, 8'd5);
      mem[1] = mk(4'h1, 1'b0, 8'h01);
      mem[2] = mk(4'hF, 1'b0, 8'h00);
      do_start();
      tick(8);
      lit("B_stb0_not_early", amp_stb0, 0);
      tick(1);
      lit("B_stb0_at_9", amp_stb0, 1);
      lit("B_amp0", amp0, 8'h01);
      tick(2);
      lit("B_done", done, 1);

      // PC wrap on the START_ADDR=127 instance
      mem[127] = mk(4'h0, 1'b0, 8'h00);
      mem[0]   = mk(4'h1, 1'b0, 8'h33);
      mem[1]   = mk(4'hF, 1'b0, 8'h00);
      start2 = 1'b1;
      tick(1);
      start2 = 1'b0;
      lit("C_addr_127", addr2, 127);
      tick(2);
      lit("C_addr_wrap", addr2, 0);
      tick(2);
      lit("C_amp0", amp0_2, 8'h33);
      lit("C_stb0", amp_stb0_2, 1);
      tick(2);
      lit("C_done", done2, 1);
      lit("C_busy", busy2, 0);
      lit("C_err", err2, 0);
      lit("C_amp1", amp1_2, 0);
      lit("C_stb1", amp_stb1_2, 0);

      // JUMP 0x10 to HALT, then to an illegal opcode
      clear_mem();
      mem[0]     = mk(4'h3, 1'b0, 8'h10);
      mem[8'h10] = mk(4'hF, 1'b0, 8'h00);
      do_start();
      lit("D_addr0", addr, 0);
      tick(2);
      lit("D_addr_jump", addr, 8'h10);
      tick(2);
      lit("D_done", done, 1);
      lit("D_err", err, 0);
      mem[8'h10] = mk(4'h7, 1'b0, 8'h00);
      do_start();
      lit("D_done_cleared", done, 0);
      tick(4);
      lit("D2_err", err, 1);
      lit("D2_done", done, 0);

      // Reset in the middle of WAIT 100
      mem[0] = mk(4'h2, 1'b0, 8'd100);
      mem[1] = mk(4'hF, 1'b0, 8'h00);
      lit("E_amp0_before", amp0, 8'h01);
      do_start();
      tick(20);
      lit("E_busy_in_wait", busy, 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      lit("E_addr", addr, 0);
      lit("E_busy", busy, 0);
      lit("E_amp0", amp0, 0);
      lit("E_amp1", amp1, 0);
      mem[0] = mk(4'h1, 1'b1, 8'h5A);
      do_start();
      tick(4);
      lit("E_rerun_amp1", amp1, 8'h5A);
      lit("E_rerun_done", done, 1);

      // start during EXEC and WAIT is ignored; start in HALTED reruns
      mem[0] = mk(4'h2, 1'b0, 8'd3);
      mem[1] = mk(4'h1, 1'b1, 8'h77);
      mem[2] = mk(4'hF, 1'b0, 8'h00);
      do_start();
      tick(1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      lit("F_addr_after_exec_start", addr, 1);
      tick(1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(3);
      lit("F_amp1", amp1, 8'h77);
      lit("F_stb1", amp_stb1, 1);
      tick(2);
      lit("F_done", done, 1);
      do_start();
      lit("F_restart_done_clear", done, 0);
      lit("F_restart_busy", busy, 1);
      tick(10);
      lit("F_rerun_done", done, 1);

      // Randomised programs: forward-only jumps so every run terminates
      for (int p = 0; p < 20; p++) begin
         rst = 1'b1;
         tick(1);
         rst = 1'b0;
         clear_mem();
         for (int a = 0; a < 24; a++) begin
            r = $urandom % 16;
            if (r < 2) begin
               mem[a] = mk(4'h0, 1'b0, 8'($urandom));
            end else if (r < 7 || r > 12) begin
               mem[a] = mk(4'h1, 1'($urandom), 8'($urandom));
            end else if (r < 9) begin
               mem[a] = mk(4'h2, 1'($urandom), 8'($urandom % 7));
            end else if (r < 11) begin
               tgt = 8'(a + 1 + int'($urandom % 6));
               mem[a] = mk(4'h3, 1'($urandom), tgt);
            end else if (r == 11) begin
               mem[a] = mk(4'hF, 1'b0, 8'h00);
            end else begin
               mem[a] = mk(4'($urandom_range(4, 14)), 1'b0, 8'($urandom));
            end
            mem[a] = mem[a] | ($urandom & 32'h07FF_FF00);
         end
         for (int c = 0; c < 200; c++) begin
            start = (($urandom % 6) == 0);
            rst   = (($urandom % 150) == 0);
            tick(1);
         end
         start = 1'b0;
         rst   = 1'b0;
      end

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
